// File: rtl/dbus_router_pkg.sv
// Shared types, default SoC map and address-match helper for the Aquila data-bus router.
package dbus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Widest address the match helper handles; callers zero-extend into it.
  localparam int unsigned MATCH_W = 64;

  localparam logic [31:0] TCM_BASE    = 32'h0000_0000;
  localparam logic [31:0] TCM_MASK    = 32'hF000_0000;
  localparam logic [31:0] DRAM_BASE   = 32'h8000_0000;
  localparam logic [31:0] DRAM_MASK   = 32'hC000_0000;
  localparam logic [31:0] MMIO_BASE   = 32'hC000_0000;
  localparam logic [31:0] MMIO_MASK   = 32'hF000_0000;
  localparam logic [31:0] SYSDEV_BASE = 32'hF000_0000;
  localparam logic [31:0] SYSDEV_MASK = 32'hF000_0000;

  // Region k sits at bits [k*32 +: 32]: 0 TCM, 1 DRAM, 2 MMIO, 3 SYSDEV.
  localparam logic [127:0] SOC_REGION_BASE = {SYSDEV_BASE, MMIO_BASE, DRAM_BASE, TCM_BASE};
  localparam logic [127:0] SOC_REGION_MASK = {SYSDEV_MASK, MMIO_MASK, DRAM_MASK, TCM_MASK};

  function automatic logic region_match(input logic [MATCH_W-1:0] addr,
                                        input logic [MATCH_W-1:0] base,
                                        input logic [MATCH_W-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/dbus_addr_decoder.sv
// Combinational base/mask region decoder; lowest matching region wins.
module dbus_addr_decoder
  import dbus_router_pkg::*;
#(
  parameter int unsigned                 XLEN        = 32,
  parameter int unsigned                 N_REGIONS   = 4,
  parameter logic [N_REGIONS*XLEN-1:0]   REGION_BASE = '0,
  parameter logic [N_REGIONS*XLEN-1:0]   REGION_MASK = '0,
  parameter int unsigned                 IDX_W       = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic [XLEN-1:0]      addr,
  output logic [N_REGIONS-1:0] hit,
  output logic [IDX_W-1:0]     idx,
  output logic                 miss
);

  logic [MATCH_W-1:0] addr_ext_s;
  logic [MATCH_W-1:0] base_ext_s;
  logic [MATCH_W-1:0] mask_ext_s;

  // Scan from the top index down so the lowest match is the last one written.
  always_comb begin
    addr_ext_s             = '0;
    addr_ext_s[XLEN-1:0]   = addr;
    base_ext_s             = '0;
    mask_ext_s             = '0;
    hit                    = '0;
    idx                    = '0;
    miss                   = 1'b1;
    for (int k = int'(N_REGIONS) - 1; k >= 0; k--) begin
      base_ext_s           = '0;
      base_ext_s[XLEN-1:0] = REGION_BASE[k*XLEN +: XLEN];
      mask_ext_s           = '0;
      mask_ext_s[XLEN-1:0] = REGION_MASK[k*XLEN +: XLEN];
      if (region_match(addr_ext_s, base_ext_s, mask_ext_s)) begin
        idx  = IDX_W'(k);
        miss = 1'b0;
      end else begin
        idx  = idx;
        miss = miss;
      end
    end
    for (int k = 0; k < int'(N_REGIONS); k++) begin
      hit[k] = !miss && (idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/dbus_region_router.sv
// Registered data-bus router: decodes a core request, strobes one region, waits for
// its ready (with optional timeout) and returns a one-cycle registered response.
module dbus_region_router
  import dbus_router_pkg::*;
#(
  parameter int unsigned               XLEN            = 32,
  parameter int unsigned               N_REGIONS       = 4,
  parameter logic [N_REGIONS*XLEN-1:0] REGION_BASE     = {N_REGIONS{32'h0}},
  parameter logic [N_REGIONS*XLEN-1:0] REGION_MASK     = {N_REGIONS{32'hF000_0000}},
  parameter int unsigned               TIMEOUT_CYCLES  = 255,
  parameter bit                        ERR_ON_UNMAPPED = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        core_strobe_i,
  input  logic [XLEN-1:0]             core_addr_i,
  input  logic                        core_rw_i,
  input  logic [XLEN/8-1:0]           core_be_i,
  input  logic [XLEN-1:0]             core_wdata_i,
  output logic [XLEN-1:0]             core_rdata_o,
  output logic                        core_ready_o,
  output logic                        core_err_o,
  output logic                        busy_o,
  output logic [N_REGIONS-1:0]        reg_strobe_o,
  output logic [XLEN-1:0]             reg_addr_o,
  output logic                        reg_rw_o,
  output logic [XLEN/8-1:0]           reg_be_o,
  output logic [XLEN-1:0]             reg_wdata_o,
  input  logic [N_REGIONS-1:0]        reg_ready_i,
  input  logic [N_REGIONS*XLEN-1:0]   reg_rdata_i,
  output logic [XLEN-1:0]             err_addr_o
);

  localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                 state_r, state_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [IDX_W-1:0]       sel_r;
  logic [N_REGIONS-1:0]   hit_s, strobe_n_s;
  logic [IDX_W-1:0]       idx_s;
  logic                   miss_s, accept_s, to_resp_s, resp_err_s, ready_sel_s;
  logic [XLEN-1:0]        rdata_sel_s, resp_rdata_s, err_addr_s;

  dbus_addr_decoder #(
    .XLEN        (XLEN),
    .N_REGIONS   (N_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .addr (core_addr_i),
    .hit  (hit_s),
    .idx  (idx_s),
    .miss (miss_s)
  );

  // Pick the selected region's ready and read data; other regions are never looked at.
  always_comb begin
    ready_sel_s = 1'b0;
    rdata_sel_s = '0;
    for (int k = 0; k < int'(N_REGIONS); k++) begin
      if (sel_r == IDX_W'(k)) begin
        ready_sel_s = reg_ready_i[k];
        rdata_sel_s = reg_rdata_i[k*XLEN +: XLEN];
      end else begin
        ready_sel_s = ready_sel_s;
        rdata_sel_s = rdata_sel_s;
      end
    end
  end

  // Next-state and response decision.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    accept_s     = 1'b0;
    to_resp_s    = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = '0;
    err_addr_s   = reg_addr_o;
    strobe_n_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (core_strobe_i) begin
          accept_s   = 1'b1;
          err_addr_s = core_addr_i;
          if (miss_s) begin
            state_n    = ST_RESP;
            to_resp_s  = 1'b1;
            resp_err_s = ERR_ON_UNMAPPED;
          end else begin
            state_n    = ST_ISSUE;
            strobe_n_s = hit_s;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (ready_sel_s) begin
          state_n      = ST_RESP;
          to_resp_s    = 1'b1;
          resp_rdata_s = reg_rw_o ? '0 : rdata_sel_s;
        end else begin
          state_n = ST_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (ready_sel_s) begin
          state_n      = ST_RESP;
          to_resp_s    = 1'b1;
          resp_rdata_s = reg_rw_o ? '0 : rdata_sel_s;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNT_W'(TIMEOUT_CYCLES))) begin
          state_n    = ST_RESP;
          to_resp_s  = 1'b1;
          resp_err_s = 1'b1;
        end else if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_n = cnt_r + CNT_W'(1);
        end else begin
          cnt_n = cnt_r;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      sel_r        <= '0;
      core_rdata_o <= '0;
      core_ready_o <= 1'b0;
      core_err_o   <= 1'b0;
      busy_o       <= 1'b0;
      reg_strobe_o <= '0;
      reg_addr_o   <= '0;
      reg_rw_o     <= 1'b0;
      reg_be_o     <= '0;
      reg_wdata_o  <= '0;
      err_addr_o   <= '0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      core_ready_o <= to_resp_s;
      core_err_o   <= resp_err_s;
      busy_o       <= (state_n != ST_IDLE);
      reg_strobe_o <= strobe_n_s;
      if (to_resp_s) core_rdata_o <= resp_rdata_s;
      if (to_resp_s && resp_err_s) err_addr_o <= err_addr_s;
      if (accept_s) begin
        sel_r       <= idx_s;
        reg_addr_o  <= core_addr_i;
        reg_rw_o    <= core_rw_i;
        reg_be_o    <= core_be_i;
        reg_wdata_o <= core_wdata_i;
      end else if (state_n == ST_IDLE) begin
        reg_addr_o  <= '0;
        reg_rw_o    <= 1'b0;
        reg_be_o    <= '0;
        reg_wdata_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dbus_region_router.sv
// Bench for dbus_region_router: instance 0 uses the SoC map, instance 1 an overlapping map
// with a short timeout and silent unmapped accesses; checked against a transaction model.
`timescale 1ns/1ps
module tb_dbus_region_router;
  import dbus_router_pkg::*;

  localparam logic [127:0] OVL_BASE = {32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [127:0] OVL_MASK = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_F000, 32'hF000_0000};
  localparam int T_A = 255;
  localparam int T_B = 4;

  logic         clk = 1'b0;
  logic         rst_n   [2];
  logic         c_strobe[2];
  logic [31:0]  c_addr  [2];
  logic         c_rw    [2];
  logic [3:0]   c_be    [2];
  logic [31:0]  c_wdata [2];
  logic [31:0]  o_rdata [2];
  logic         o_ready [2];
  logic         o_err   [2];
  logic         o_busy  [2];
  logic [3:0]   o_strobe[2];
  logic [31:0]  o_addr  [2];
  logic         o_rw    [2];
  logic [3:0]   o_be    [2];
  logic [31:0]  o_wdata [2];
  logic [3:0]   r_ready [2];
  logic [127:0] r_rdata [2];
  logic [31:0]  o_eaddr [2];

  logic [31:0]  prev_rdata[2];
  logic [31:0]  prev_eaddr[2];
  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  dbus_region_router #(
    .XLEN(32), .N_REGIONS(4), .REGION_BASE(SOC_REGION_BASE), .REGION_MASK(SOC_REGION_MASK),
    .TIMEOUT_CYCLES(T_A), .ERR_ON_UNMAPPED(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n[0]), .core_strobe_i(c_strobe[0]), .core_addr_i(c_addr[0]),
    .core_rw_i(c_rw[0]), .core_be_i(c_be[0]), .core_wdata_i(c_wdata[0]),
    .core_rdata_o(o_rdata[0]), .core_ready_o(o_ready[0]), .core_err_o(o_err[0]),
    .busy_o(o_busy[0]), .reg_strobe_o(o_strobe[0]), .reg_addr_o(o_addr[0]), .reg_rw_o(o_rw[0]),
    .reg_be_o(o_be[0]), .reg_wdata_o(o_wdata[0]), .reg_ready_i(r_ready[0]),
    .reg_rdata_i(r_rdata[0]), .err_addr_o(o_eaddr[0])
  );

  dbus_region_router #(
    .XLEN(32), .N_REGIONS(4), .REGION_BASE(OVL_BASE), .REGION_MASK(OVL_MASK),
    .TIMEOUT_CYCLES(T_B), .ERR_ON_UNMAPPED(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n[1]), .core_strobe_i(c_strobe[1]), .core_addr_i(c_addr[1]),
    .core_rw_i(c_rw[1]), .core_be_i(c_be[1]), .core_wdata_i(c_wdata[1]),
    .core_rdata_o(o_rdata[1]), .core_ready_o(o_ready[1]), .core_err_o(o_err[1]),
    .busy_o(o_busy[1]), .reg_strobe_o(o_strobe[1]), .reg_addr_o(o_addr[1]), .reg_rw_o(o_rw[1]),
    .reg_be_o(o_be[1]), .reg_wdata_o(o_wdata[1]), .reg_ready_i(r_ready[1]),
    .reg_rdata_i(r_rdata[1]), .err_addr_o(o_eaddr[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Region owning an address, by top nibble; -1 = unmapped.
  function automatic int exp_region(input int d, input logic [31:0] a);
    logic [3:0] nib;
    nib = a[31:28];
    if (d == 0) begin
      if (nib == 4'h0) return 0;
      if (nib >= 4'h8 && nib <= 4'hB) return 1;
      if (nib == 4'hC) return 2;
      if (nib == 4'hF) return 3;
      return -1;
    end
    if (nib == 4'h0) return 0;
    if (nib == 4'h2) return 2;
    if (nib == 4'h3) return 3;
    return -1;
  endfunction

  task automatic drive_regions(input int d, input int sel, input bit rdy, input logic [31:0] rd,
                               input bit noise);
    logic [127:0] rv;
    logic [3:0]   rb;
    for (int k = 0; k < 4; k++) rv[k*32 +: 32] = $urandom;
    rb = noise ? 4'($urandom) : 4'h0;
    if (sel >= 0) begin
      rb[sel] = rdy;
      if (rdy) rv[sel*32 +: 32] = rd;
    end
    r_ready[d] = rb;
    r_rdata[d] = rv;
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_busy"}, 32'(o_busy[d]), 32'd0);
    check({tag, "_ready"}, 32'(o_ready[d]), 32'd0);
    check({tag, "_err"}, 32'(o_err[d]), 32'd0);
    check({tag, "_strobe"}, 32'(o_strobe[d]), 32'd0);
    check({tag, "_raddr"}, o_addr[d], 32'd0);
    check({tag, "_rw"}, 32'(o_rw[d]), 32'd0);
    check({tag, "_be"}, 32'(o_be[d]), 32'd0);
    check({tag, "_wdata"}, o_wdata[d], 32'd0);
    check({tag, "_rdata"}, o_rdata[d], prev_rdata[d]);
    check({tag, "_eaddr"}, o_eaddr[d], prev_eaddr[d]);
  endtask

  // One complete access; dly = cycles after the ISSUE cycle at which the region answers.
  task automatic run_txn(input int d, input logic [31:0] a, input logic rw, input logic [3:0] be,
                         input logic [31:0] wd, input int dly, input logic [31:0] rd,
                         input bit noise);
    int sel, lat, tmo;
    bit err_exp;
    logic [31:0] rexp;
    sel = exp_region(d, a);
    tmo = (d == 1) ? T_B : T_A;
    if (sel < 0) begin
      lat = 1; err_exp = (d == 0); rexp = 32'd0;
    end else if (tmo == 0 || dly <= tmo) begin
      lat = dly + 2; err_exp = 1'b0; rexp = rw ? 32'd0 : rd;
    end else begin
      lat = tmo + 2; err_exp = 1'b1; rexp = 32'd0;
    end
    c_strobe[d] = 1'b1; c_addr[d] = a; c_rw[d] = rw; c_be[d] = be; c_wdata[d] = wd;
    @(posedge clk); #1;
    for (int c = 1; c <= lat + 1; c++) begin
      c_strobe[d] = (noise && c <= lat) ? 1'($urandom) : 1'b0;
      c_addr[d] = $urandom; c_rw[d] = 1'($urandom); c_be[d] = 4'($urandom); c_wdata[d] = $urandom;
      drive_regions(d, sel, (sel >= 0) && (c == dly + 1), rd, noise);
      if (c == lat) begin
        prev_rdata[d] = rexp;
        if (err_exp) prev_eaddr[d] = a;
      end
      @(negedge clk);
      check("strobe", 32'(o_strobe[d]), (c == 1 && sel >= 0) ? (32'd1 << sel) : 32'd0);
      check("busy", 32'(o_busy[d]), 32'(c <= lat));
      check("ready", 32'(o_ready[d]), 32'(c == lat));
      check("err", 32'(o_err[d]), 32'((c == lat) && err_exp));
      check("rdata", o_rdata[d], prev_rdata[d]);
      check("err_addr", o_eaddr[d], prev_eaddr[d]);
      check("reg_addr", o_addr[d], (c <= lat) ? a : 32'd0);
      check("reg_rw", 32'(o_rw[d]), (c <= lat) ? 32'(rw) : 32'd0);
      check("reg_be", 32'(o_be[d]), (c <= lat) ? 32'(be) : 32'd0);
      check("reg_wdata", o_wdata[d], (c <= lat) ? wd : 32'd0);
      if (c <= lat) begin
        @(posedge clk); #1;
      end
    end
    r_ready[d] = 4'h0;
  endtask

  initial begin
    int d;
    n_chk = 0;
    n_fail = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; c_strobe[k] = 1'b0; c_addr[k] = 32'd0; c_rw[k] = 1'b0;
      c_be[k] = 4'd0; c_wdata[k] = 32'd0; r_ready[k] = 4'd0; r_rdata[k] = 128'd0;
      prev_rdata[k] = 32'd0; prev_eaddr[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios.
    run_txn(0, 32'hC000_0010, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    run_txn(0, 32'h8000_0004, 1'b1, 4'b0011, 32'h1234_5678, 6, 32'hCAFE_F00D, 1'b0);
    run_txn(1, 32'h2000_0040, 1'b0, 4'hF, 32'h0, 1000, 32'h1111_2222, 1'b0);
    run_txn(1, 32'h3000_0080, 1'b0, 4'hF, 32'h0, T_B, 32'h5A5A_A5A5, 1'b0);
    run_txn(1, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_CAFE, 1'b1);
    run_txn(0, 32'h5000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h7777_7777, 1'b1);
    run_txn(1, 32'h5000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h7777_7777, 1'b1);

    // Reset in the middle of a WAIT with a stray core strobe and foreign readies.
    c_strobe[0] = 1'b1; c_addr[0] = 32'hC000_0020; c_rw[0] = 1'b0; c_be[0] = 4'hF;
    c_wdata[0] = 32'd0;
    @(posedge clk); #1;
    c_strobe[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    c_strobe[0] = 1'b1; c_addr[0] = 32'h0000_0000; r_ready[0] = 4'b1011;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_busy", 32'(o_busy[0]), 32'd1);
    check("wait_ready", 32'(o_ready[0]), 32'd0);
    check("wait_strobe", 32'(o_strobe[0]), 32'd0);
    check("wait_raddr", o_addr[0], 32'hC000_0020);
    #1 rst_n[0] = 1'b0;
    #1;
    prev_rdata[0] = 32'd0;
    prev_eaddr[0] = 32'd0;
    check_idle(0, "async_rst");
    c_strobe[0] = 1'b0;
    r_ready[0] = 4'b0100;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle(0, "post_rst");
      @(posedge clk); #1;
    end
    r_ready[0] = 4'd0;

    // Randomized accesses on both instances.
    for (int i = 0; i < 60; i++) begin
      d = i % 2;
      run_txn(d, {4'($urandom_range(0, 15)), 28'($urandom)}, 1'($urandom), 4'($urandom),
              $urandom, $urandom_range(0, 7), $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
